// File: rtl/npc_pkg.sv
// Shared encodings and helpers for the fetch stage: branch/jump kinds,
// comparator bit positions, the IF/ID payload and the branch offset helper.
package npc_pkg;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_BEQ  = 3'd1,
      BR_BNE  = 3'd2,
      BR_BGEZ = 3'd3,
      BR_BGTZ = 3'd4,
      BR_BLEZ = 3'd5,
      BR_BLTZ = 3'd6,
      BR_RSVD = 3'd7
   } brType_e;

   typedef enum logic [1:0] {
      JMP_NONE = 2'd0,
      JMP_IDX  = 2'd1,
      JMP_REG  = 2'd2,
      JMP_RSVD = 2'd3
   } jmpType_e;

   localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

   // Bit positions inside the ID comparator result
   localparam int CMP_EQ   = 0;
   localparam int CMP_GEZ  = 1;
   localparam int CMP_ZERO = 2;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc8;
   } ifid_t;

   // Sign-extended word offset of a 16-bit branch immediate
   function automatic logic signed [31:0] brOffset(input logic [15:0] imm);
      logic signed [31:0] ext;
      ext = {{16{imm[15]}}, imm};
      return ext <<< 2;
   endfunction

endpackage

// File: rtl/fetch_ifid_if.sv
// Instruction-memory port of the fetch stage: the core drives the PC and the
// memory answers with the word at that address in the same cycle.
interface fetch_ifid_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;

   modport master (output imem_addr, input imem_rdata);
   modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/br_cond.sv
// Branch-taken decision from the ID branch kind and the rs/rt comparator bits.
module br_cond
   import npc_pkg::*;
(
   input  logic [2:0] id_br_type,
   input  logic [2:0] id_cmp,
   output logic       taken
);

   logic eq;
   logic gez;
   logic zero;

   assign eq   = id_cmp[CMP_EQ];
   assign gez  = id_cmp[CMP_GEZ];
   assign zero = id_cmp[CMP_ZERO];

   always_comb begin
      taken = 1'b0;
      case (brType_e'(id_br_type))
         BR_BEQ:  taken = eq;
         BR_BNE:  taken = !eq;
         BR_BGEZ: taken = gez;
         BR_BGTZ: taken = gez && !zero;
         BR_BLEZ: taken = !gez || zero;
         BR_BLTZ: taken = !gez;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/fetch_ifid.sv
// Fetch stage with the IF/ID register: PC register, next-PC selection for
// branches/jumps resolved in ID (one delay slot, no flush), IF/ID latch.
module fetch_ifid
   import npc_pkg::*;
#(
   parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic [2:0]         id_br_type,
   input  logic [1:0]         id_jump,
   input  logic [2:0]         id_cmp,
   input  logic [31:0]        id_rs_data,
   fetch_ifid_if.master       imemBus,
   output logic [31:0]        id_instr,
   output logic [31:0]        id_pc,
   output logic [31:0]        id_pc8,
   output logic               redirect
);

   logic [31:0] pcP0;
   ifid_t       ifidP1;

   logic        brTaken;
   logic        idLive;
   logic [31:0] pcSeq;
   logic [31:0] jumpIdxTarget;
   logic [31:0] jumpRegTarget;
   logic [31:0] brTarget;
   logic [31:0] nextPc;
   logic        redirectSel;

   br_cond uBrCond (
      .id_br_type (id_br_type),
      .id_cmp     (id_cmp),
      .taken      (brTaken)
   );

   // IF stage: target candidates
   assign pcSeq         = pcP0 + 32'd4;
   assign jumpIdxTarget = {ifidP1.pc[31:28], ifidP1.instr[25:0], 2'b00};
   assign jumpRegTarget = id_rs_data & 32'hFFFF_FFFC;
   assign brTarget      = ifidP1.pc + 32'd4 + $unsigned(brOffset(ifidP1.instr[15:0]));

   // A nop in ID never redirects, and a stalled cycle resolves nothing
   assign idLive = (|ifidP1.instr) && !stall;

   always_comb begin
      nextPc      = pcSeq;
      redirectSel = 1'b0;
      if (idLive) begin
         case (jmpType_e'(id_jump))
            JMP_IDX: begin
               nextPc      = jumpIdxTarget;
               redirectSel = 1'b1;
            end
            JMP_REG: begin
               nextPc      = jumpRegTarget;
               redirectSel = 1'b1;
            end
            default: begin
               if (brTaken) begin
                  nextPc      = brTarget;
                  redirectSel = 1'b1;
               end
            end
         endcase
      end
   end

   // PC register and IF/ID latch; the delay-slot word is always captured
   always_ff @(posedge clk) begin
      if (!reset) begin
         pcP0         <= PC_RESET;
         ifidP1.instr <= 32'd0;
         ifidP1.pc    <= 32'd0;
         ifidP1.pc8   <= 32'd8;
      end else if (!stall) begin
         pcP0         <= nextPc;
         ifidP1.instr <= imemBus.imem_rdata;
         ifidP1.pc    <= pcP0;
         ifidP1.pc8   <= pcP0 + 32'd8;
      end
   end

   assign imemBus.imem_addr = pcP0;
   assign id_instr          = ifidP1.instr;
   assign id_pc             = ifidP1.pc;
   assign id_pc8            = ifidP1.pc8;
   assign redirect          = redirectSel;

endmodule

// File: tb/tb_fetch_ifid.sv
// Directed bench for fetch_ifid: a small ROM feeds the fetch port, the bench
// plays the ID decoder, and expected post-edge state is queued per step.
module tb_fetch_ifid;

   logic        clk;
   logic        reset;
   logic        stall;
   logic [2:0]  id_br_type;
   logic [1:0]  id_jump;
   logic [2:0]  id_cmp;
   logic [31:0] id_rs_data;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc8;
   logic        redirect;

   int compared;
   int mismatched;

   typedef struct {
      string       tag;
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc8;
   } exp_t;

   exp_t sb[$];

   fetch_ifid_if bus ();

   fetch_ifid dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .id_br_type (id_br_type),
      .id_jump    (id_jump),
      .id_cmp     (id_cmp),
      .id_rs_data (id_rs_data),
      .imemBus    (bus),
      .id_instr   (id_instr),
      .id_pc      (id_pc),
      .id_pc8     (id_pc8),
      .redirect   (redirect)
   );

   // Program image: a few real branch/jump words, filler elsewhere
   function automatic logic [31:0] romWord(input logic [31:0] a);
      case (a)
         32'h0000_3010: return 32'h1000_0004;   // beq  imm +4
         32'h0000_3040: return 32'h1C20_FFFF;   // bgtz imm -1
         32'h0000_3048: return 32'h1820_FFFE;   // blez imm -2
         32'h3000_0004: return 32'h0C00_0C00;   // jal  index 0xC00
         default:       return {16'h2400, a[15:0]};
      endcase
   endfunction

   assign bus.imem_rdata = romWord(bus.imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic step(input string tag, input logic rstV, input logic stV,
                       input logic [2:0] brV, input logic [1:0] jV, input logic [2:0] cV,
                       input logic [31:0] rsV, input logic redirExp,
                       input logic [31:0] aExp, input logic [31:0] iExp, input logic [31:0] pExp);
      exp_t e;
      exp_t got;
      reset      = rstV;
      stall      = stV;
      id_br_type = brV;
      id_jump    = jV;
      id_cmp     = cV;
      id_rs_data = rsV;
      #1;
      chk({tag, "/redirect"}, {31'd0, redirect}, {31'd0, redirExp});
      e.tag   = tag;
      e.addr  = aExp;
      e.instr = iExp;
      e.pc    = pExp;
      e.pc8   = pExp + 32'd8;
      sb.push_back(e);
      @(negedge clk);
      got = sb.pop_front();
      chk({got.tag, "/imem_addr"}, bus.imem_addr, got.addr);
      chk({got.tag, "/id_instr"},  id_instr,      got.instr);
      chk({got.tag, "/id_pc"},     id_pc,         got.pc);
      chk({got.tag, "/id_pc8"},    id_pc8,        got.pc8);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset      = 1'b0;
      stall      = 1'b0;
      id_br_type = 3'd0;
      id_jump    = 2'd0;
      id_cmp     = 3'd0;
      id_rs_data = 32'd0;
      repeat (2) @(negedge clk);

      // reset state, then sequential fetch; a jump request against a nop is ignored
      step("rst_hold", 0, 0, 0, 0, 3'b000, 32'h0,         0, 32'h0000_3000, 32'h0,                 32'h0);
      step("rel_1",    1, 0, 0, 2, 3'b000, 32'h5000,      0, 32'h0000_3004, romWord(32'h3000),     32'h3000);
      step("rel_2",    1, 0, 0, 0, 3'b000, 32'h0,         0, 32'h0000_3008, romWord(32'h3004),     32'h3004);

      // beq taken then not taken
      step("jr_3010",  1, 0, 0, 2, 3'b000, 32'h3010,      1, 32'h0000_3010, romWord(32'h3008),     32'h3008);
      step("seq_beq",  1, 0, 0, 0, 3'b000, 32'h0,         0, 32'h0000_3014, 32'h1000_0004,         32'h3010);
      step("beq_tk",   1, 0, 1, 0, 3'b001, 32'h0,         1, 32'h0000_3024, romWord(32'h3014),     32'h3014);
      step("jr_back",  1, 0, 0, 2, 3'b000, 32'h3010,      1, 32'h0000_3010, romWord(32'h3024),     32'h3024);
      step("seq_beq2", 1, 0, 0, 0, 3'b000, 32'h0,         0, 32'h0000_3014, 32'h1000_0004,         32'h3010);
      step("beq_nt",   1, 0, 1, 0, 3'b000, 32'h0,         0, 32'h0000_3018, romWord(32'h3014),     32'h3014);

      // backward bgtz taken/not taken, blez taken, reserved, bltz
      step("jr_3040",  1, 0, 0, 2, 3'b000, 32'h3040,      1, 32'h0000_3040, romWord(32'h3018),     32'h3018);
      step("seq_bgtz", 1, 0, 0, 0, 3'b000, 32'h0,         0, 32'h0000_3044, 32'h1C20_FFFF,         32'h3040);
      step("bgtz_tk",  1, 0, 4, 0, 3'b010, 32'h0,         1, 32'h0000_3040, romWord(32'h3044),     32'h3044);
      step("seq_bgtz2",1, 0, 0, 0, 3'b000, 32'h0,         0, 32'h0000_3044, 32'h1C20_FFFF,         32'h3040);
      step("bgtz_nt",  1, 0, 4, 0, 3'b110, 32'h0,         0, 32'h0000_3048, romWord(32'h3044),     32'h3044);
      step("seq_blez", 1, 0, 0, 0, 3'b000, 32'h0,         0, 32'h0000_304C, 32'h1820_FFFE,         32'h3048);
      step("blez_tk",  1, 0, 5, 0, 3'b110, 32'h0,         1, 32'h0000_3044, romWord(32'h304C),     32'h304C);
      step("br_rsvd",  1, 0, 7, 0, 3'b111, 32'h0,         0, 32'h0000_3048, romWord(32'h3044),     32'h3044);
      step("bltz_tk",  1, 0, 6, 0, 3'b000, 32'h0,         1, 32'h0000_F158, 32'h1820_FFFE,         32'h3048);

      // jal, jr, jump-over-branch priority, reserved jump
      step("jr_3k4",   1, 0, 0, 2, 3'b000, 32'h3000_0004, 1, 32'h3000_0004, romWord(32'hF158),     32'hF158);
      step("seq_jal",  1, 0, 0, 0, 3'b000, 32'h0,         0, 32'h3000_0008, 32'h0C00_0C00,         32'h3000_0004);
      step("jal",      1, 0, 0, 1, 3'b000, 32'h0,         1, 32'h3000_3000, romWord(32'h3000_0008),32'h3000_0008);
      step("jr_3403",  1, 0, 0, 2, 3'b000, 32'h0000_3403, 1, 32'h0000_3400, romWord(32'h3000_3000),32'h3000_3000);
      step("jmp_prio", 1, 0, 1, 1, 3'b001, 32'h0,         1, 32'h3000_C000, romWord(32'h3400),     32'h3400);
      step("jmp_rsvd", 1, 0, 0, 3, 3'b000, 32'h1234,      0, 32'h3000_C004, romWord(32'h3000_C000),32'h3000_C000);

      // PC wrap past the top of the address space
      step("jr_top",   1, 0, 0, 2, 3'b000, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, romWord(32'h3000_C004),32'h3000_C004);
      step("wrap",     1, 0, 0, 0, 3'b000, 32'h0,         0, 32'h0000_0000, romWord(32'hFFFF_FFFC),32'hFFFF_FFFC);

      // stall with a taken beq in ID and a toggling comparator
      step("jr_3010b", 1, 0, 0, 2, 3'b000, 32'h3010,      1, 32'h0000_3010, romWord(32'h0),        32'h0);
      step("seq_beq3", 1, 0, 0, 0, 3'b000, 32'h0,         0, 32'h0000_3014, 32'h1000_0004,         32'h3010);
      step("stall_1",  1, 1, 1, 0, 3'b001, 32'h0,         0, 32'h0000_3014, 32'h1000_0004,         32'h3010);
      step("stall_2",  1, 1, 1, 0, 3'b000, 32'h0,         0, 32'h0000_3014, 32'h1000_0004,         32'h3010);
      step("stall_3",  1, 1, 1, 0, 3'b001, 32'h0,         0, 32'h0000_3014, 32'h1000_0004,         32'h3010);
      step("unstall",  1, 0, 1, 0, 3'b001, 32'h0,         1, 32'h0000_3024, romWord(32'h3014),     32'h3014);

      // reset wins over stall
      step("rst_stall",0, 1, 0, 0, 3'b000, 32'h0,         0, 32'h0000_3000, 32'h0,                 32'h0);
      step("rel_again",1, 0, 0, 0, 3'b000, 32'h0,         0, 32'h0000_3004, romWord(32'h3000),     32'h3000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
